// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM target: single-port word array with synchronous read,
// classic cycles and CTI/BTE bursts. Optional range check: WB_SRAM_SLAVE_RANGE_ERR_EN.
module wb_sram_slave #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int BYTES = WB_DATA_WIDTH / 8;
  localparam int BO    = $clog2(BYTES);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  typedef logic [MEM_ADDR_BITS-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_t;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  state_t                   state_q, state_d;
  idx_t                     cur_addr_q, cur_addr_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_r_q;

  logic req, rd_en, wr_en, clr_dat;
  logic adr_oor, nxt_oor;
  idx_t adr_idx, nxt_idx, wrap_mask;
  logic unused_adr;

  assign req        = CYC & STB;
  assign unused_adr = ^{ADR, ADDR_BASE};

`ifdef WB_SRAM_SLAVE_RANGE_ERR_EN
  localparam logic [WB_ADDR_WIDTH:0] SPAN = (WB_ADDR_WIDTH+1)'(DEPTH * BYTES);
  logic [WB_ADDR_WIDTH-1:0] adr_off;
  assign adr_off = ADR - ADDR_BASE;
  assign adr_idx = adr_off[MEM_ADDR_BITS+BO-1:BO];
  assign adr_oor = (ADR < ADDR_BASE) || ({1'b0, adr_off} >= SPAN);
  // Only a linear burst can leave the window; wrapping bursts keep their upper index bits.
  assign nxt_oor = (BTE == 2'b00) && (cur_addr_q == idx_t'(DEPTH - 1));
`else
  assign adr_idx = ADR[MEM_ADDR_BITS+BO-1:BO];
  assign adr_oor = 1'b0;
  assign nxt_oor = 1'b0;
`endif

  always_comb begin
    case (BTE)
      2'b01:   wrap_mask = idx_t'(3);
      2'b10:   wrap_mask = idx_t'(7);
      2'b11:   wrap_mask = idx_t'(15);
      default: wrap_mask = '1;
    endcase
    nxt_idx = (cur_addr_q & ~wrap_mask) | ((cur_addr_q + idx_t'(1)) & wrap_mask);
  end

  // ACK is always high while in CLASSIC or BURST, so every request seen there completes a beat.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    clr_dat    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !err_q) begin
          cur_addr_d = adr_idx;
          if (adr_oor) begin
            err_d   = 1'b1;
            clr_dat = 1'b1;
          end else begin
            rd_en   = 1'b1;
            ack_d   = 1'b1;
            state_d = (CTI == 3'b010) ? S_BURST : S_CLASSIC;
          end
        end
      end
      S_CLASSIC: begin
        wr_en   = req & WE;
        state_d = S_IDLE;
      end
      S_BURST: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          wr_en = WE;
          if (CTI == 3'b010) begin
            if (nxt_oor) begin
              err_d   = 1'b1;
              clr_dat = 1'b1;
              state_d = S_IDLE;
            end else begin
              cur_addr_d = nxt_idx;
              rd_en      = 1'b1;
              ack_d      = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      if (clr_dat)
        dat_r_q <= '0;
      else if (rd_en)
        dat_r_q <= mem[cur_addr_d];
    end
  end

  // Array is not reset; a write is suppressed on a reset edge so an interrupted burst leaves it intact.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (SEL[b])
          mem[cur_addr_q][8*b +: 8] <= DAT_W[8*b +: 8];
      end
    end
  end

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign DAT_R = dat_r_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: table of classic transfers plus hand-written burst,
// STB-drop, reset and address-range sequences.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ADR;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic [31:0] DAT_W;
  logic [31:0] DAT_R;
  logic        CYC, STB, WE;
  logic [3:0]  SEL;
  logic        ACK, ERR;

  always #5 clk = ~clk;

  localparam logic [31:0] B = 32'h1000;

  wb_sram_slave #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .MEM_ADDR_BITS(4),
    .ADDR_BASE    (32'h1000)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .ADR  (ADR),
    .CTI  (CTI),
    .BTE  (BTE),
    .DAT_W(DAT_W),
    .DAT_R(DAT_R),
    .CYC  (CYC),
    .STB  (STB),
    .WE   (WE),
    .SEL  (SEL),
    .ACK  (ACK),
    .ERR  (ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One classic access; ACK (or ERR) must appear exactly one cycle after presentation and last one cycle.
  task automatic classic(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [2:0] cti,
                         input logic [31:0] exp, input logic exp_err, input string nm);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_W = dat; CTI = cti; BTE = 2'b00;
    @(negedge clk);
    chk({nm, " ack"}, 32'(ACK), 32'(!exp_err));
    chk({nm, " err"}, 32'(ERR), 32'(exp_err));
    if (!we || exp_err) chk({nm, " dat_r"}, DAT_R, exp_err ? 32'h0 : exp);
    @(negedge clk);
    chk({nm, " ack end"}, 32'(ACK), 32'h0);
    chk({nm, " err end"}, 32'(ERR), 32'h0);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd_adr[5];
    logic [31:0] rd_exp[5];

    rstn = 1'b0; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    ADR = '0; CTI = '0; BTE = '0; DAT_W = '0; SEL = '0;
    repeat (3) @(negedge clk);
    chk("reset ack", 32'(ACK), 32'h0);
    chk("reset err", 32'(ERR), 32'h0);
    chk("reset dat_r", DAT_R, 32'h0);
    rstn = 1'b1;

    tv[0]  = '{1'b1, B + 32'h10, 4'hF, 32'hDEADBEEF, 3'b000, 32'h0};
    tv[1]  = '{1'b0, B + 32'h10, 4'hF, 32'h0,        3'b000, 32'hDEADBEEF};
    tv[2]  = '{1'b1, B + 32'h14, 4'hF, 32'h11223344, 3'b000, 32'h0};
    tv[3]  = '{1'b1, B + 32'h14, 4'h2, 32'hAABBCCDD, 3'b000, 32'h0};
    tv[4]  = '{1'b0, B + 32'h14, 4'hF, 32'h0,        3'b000, 32'h1122CC44};
    tv[5]  = '{1'b1, B + 32'h00, 4'hF, 32'h000000A0, 3'b000, 32'h0};
    tv[6]  = '{1'b1, B + 32'h04, 4'hF, 32'h000000A1, 3'b000, 32'h0};
    tv[7]  = '{1'b1, B + 32'h08, 4'hF, 32'h000000A2, 3'b000, 32'h0};
    tv[8]  = '{1'b1, B + 32'h0C, 4'hF, 32'h000000A3, 3'b000, 32'h0};
    tv[9]  = '{1'b1, B + 32'h20, 4'hF, 32'h88888888, 3'b000, 32'h0};
    tv[10] = '{1'b1, B + 32'h24, 4'hF, 32'hFFFFFFFF, 3'b000, 32'h0};
    tv[11] = '{1'b1, B + 32'h24, 4'h9, 32'h12345678, 3'b111, 32'h0};
    tv[12] = '{1'b0, B + 32'h24, 4'h0, 32'h0,        3'b011, 32'h12FFFF78};
    tv[13] = '{1'b1, B + 32'h28, 4'hF, 32'h0,        3'b000, 32'h0};
    tv[14] = '{1'b1, B + 32'h2C, 4'hF, 32'h0,        3'b000, 32'h0};
    tv[15] = '{1'b1, B + 32'h30, 4'hF, 32'hCCCC0012, 3'b000, 32'h0};

    for (int i = 0; i < 16; i++)
      classic(tv[i].we, tv[i].adr, tv[i].sel, tv[i].dat, tv[i].cti, tv[i].exp, 1'b0,
              $sformatf("vec%0d", i));

    // Linear burst read of words 0..3
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = B; CTI = 3'b010; BTE = 2'b00; SEL = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("lin beat%0d ack", i), 32'(ACK), 32'h1);
      chk($sformatf("lin beat%0d dat_r", i), DAT_R, 32'hA0 + 32'(i));
      ADR = B + 32'(4 * (i + 1));
      CTI = (i == 3) ? 3'b111 : 3'b010;
    end
    @(negedge clk);
    chk("lin end ack", 32'(ACK), 32'h0);
    CYC = 1'b0; STB = 1'b0;

    // Wrap4 burst write starting at word 6
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = B + 32'h18; CTI = 3'b010; BTE = 2'b01;
    SEL = 4'hF; DAT_W = 32'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wrap beat%0d ack", i), 32'(ACK), 32'h1);
      DAT_W = 32'(i + 1);
      CTI   = (i == 3) ? 3'b111 : 3'b010;
    end
    @(negedge clk);
    chk("wrap end ack", 32'(ACK), 32'h0);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; BTE = 2'b00;
    rd_adr = '{B + 32'h18, B + 32'h1C, B + 32'h10, B + 32'h14, B + 32'h20};
    rd_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h88888888};
    for (int i = 0; i < 5; i++)
      classic(1'b0, rd_adr[i], 4'hF, 32'h0, 3'b000, rd_exp[i], 1'b0, $sformatf("wrap rd%0d", i));

    // STB dropped while beat 2 of a linear write burst is acknowledged
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = B + 32'h28; CTI = 3'b010; BTE = 2'b00;
    SEL = 4'hF; DAT_W = 32'h100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("drop beat%0d ack", i), 32'(ACK), 32'h1);
      DAT_W = 32'h100 + 32'(i);
      CTI   = 3'b010;
    end
    @(negedge clk);
    chk("drop beat2 ack", 32'(ACK), 32'h1);
    STB = 1'b0; DAT_W = 32'h00000BAD;
    @(negedge clk);
    chk("drop ack low", 32'(ACK), 32'h0);
    CYC = 1'b0; WE = 1'b0;
    rd_adr[0:2] = '{B + 32'h28, B + 32'h2C, B + 32'h30};
    rd_exp[0:2] = '{32'h100, 32'h101, 32'hCCCC0012};
    for (int i = 0; i < 3; i++)
      classic(1'b0, rd_adr[i], 4'hF, 32'h0, 3'b000, rd_exp[i], 1'b0, $sformatf("drop rd%0d", i));

    // Reset asserted during a write burst
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = B; CTI = 3'b010; BTE = 2'b00;
    SEL = 4'hF; DAT_W = 32'hA0;
    @(negedge clk);
    chk("rstb beat0 ack", 32'(ACK), 32'h1);
    DAT_W = 32'hA0;
    @(negedge clk);
    chk("rstb beat1 ack", 32'(ACK), 32'h1);
    chk("rstb beat1 dat_r", DAT_R, 32'hA1);
    DAT_W = 32'h00000BAD; rstn = 1'b0;
    @(negedge clk);
    chk("rstb ack", 32'(ACK), 32'h0);
    chk("rstb err", 32'(ERR), 32'h0);
    chk("rstb dat_r", DAT_R, 32'h0);
    rstn = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    classic(1'b0, B + 32'h04, 4'hF, 32'h0, 3'b000, 32'hA1, 1'b0, "rstb rd1");
    classic(1'b0, B + 32'h00, 4'hF, 32'h0, 3'b000, 32'hA0, 1'b0, "rstb rd0");

    // Access 0x40 bytes past the window base
`ifdef WB_SRAM_SLAVE_RANGE_ERR_EN
    classic(1'b1, 32'h1040, 4'hF, 32'h55, 3'b000, 32'h0, 1'b1, "range wr");
    classic(1'b0, B, 4'hF, 32'h0, 3'b000, 32'hA0, 1'b0, "range rd0");
`else
    classic(1'b1, 32'h1040, 4'hF, 32'h55, 3'b000, 32'h0, 1'b0, "alias wr");
    classic(1'b0, B, 4'hF, 32'h0, 3'b000, 32'h55, 1'b0, "alias rd0");
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
